// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART constants and state encoding for the tx serializer and its receiver twin.
// Latency: n/a (types and elaboration-time constants only).
// Backpressure: n/a.
//
// Contents:
//   *_DEF        default frame timing (50 MHz core, 115200 baud, 8N4 frame)
//   uart_state_e two-state frame FSM encoding (IDLE, SEND)
//   stop_bits()  number of stop bits padding a frame out to packet_size
package uart_tx_serializer_pkg;

  localparam int CLOCKS_PER_PULSE_DEF = 434;
  localparam int BITS_PER_WORD_DEF    = 8;
  localparam int PACKET_SIZE_DEF      = 13;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } uart_state_e;

  // Elaboration-time helper only; never instantiated as hardware.
  function automatic int stop_bits(input int packet_size, input int bits_per_word);
    return packet_size - bits_per_word - 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Word handshake bus feeding the UART serializer.
// Latency: n/a (wires only).
// Backpressure: s_ready from the slave; a word moves on s_valid & s_ready at a clock edge.
//
// Signals:
//   s_data  word to transmit (master -> slave)
//   s_valid s_data is valid  (master -> slave)
//   s_ready slave can take a word this cycle (slave -> master)
interface uart_tx_serializer_if
  import uart_tx_serializer_pkg::*;
#(
  parameter int BITS_PER_WORD = BITS_PER_WORD_DEF
);

  logic [BITS_PER_WORD-1:0] s_data;
  logic                     s_valid;
  logic                     s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/uart_tx_serializer_baud_counter.sv
// Bit-period divider: counts enabled cycles and pulses tick on the last cycle of each bit.
// Latency: tick is combinational from the count; first tick CLOCKS_PER_PULSE-1 cycles after enable.
// Backpressure: none; dropping en clears the count so every enable starts a fresh bit period.
//
// Ports:
//   clk, rstn  clock and asynchronous active-low clear
//   en         count while high, hold at zero while low
//   tick       high in the terminal-count cycle (count == CLOCKS_PER_PULSE-1) while enabled
module uart_baud_counter
  import uart_tx_serializer_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W   = $clog2(CLOCKS_PER_PULSE);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLOCKS_PER_PULSE - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: one word per handshake, sent LSB-first as start, data, then stop bits.
// Latency: start bit on tx the cycle after the accepting edge; frame lasts PACKET_SIZE*CLOCKS_PER_PULSE cycles.
// Backpressure: s_ready is high in IDLE and in the final cycle of the last stop bit, so frames can abut.
//
// Ports:
//   clk, rstn  clock and asynchronous active-low reset (abandons any frame in flight)
//   s          word handshake (slave side: s_data, s_valid in; s_ready out)
//   tx         serial line, idle high, driven straight from a flop
//   busy       a frame is on the line
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
  parameter int BITS_PER_WORD    = BITS_PER_WORD_DEF,
  parameter int PACKET_SIZE      = PACKET_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  uart_tx_serializer_if.slave  s,
  output logic                 tx,
  output logic                 busy
);

  localparam int               STOP_BITS = stop_bits(PACKET_SIZE, BITS_PER_WORD);
  localparam int               BIT_W     = $clog2(PACKET_SIZE);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(PACKET_SIZE - 1);

  uart_state_e            state_q;
  uart_state_e            state_d;
  logic [PACKET_SIZE-1:0] shift_q;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic                   tick;
  logic                   frame_end;
  logic                   ready;
  logic                   accept;

  uart_baud_counter #(
    .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE)
  ) u_baud (
    .clk  (clk),
    .rstn (rstn),
    .en   (state_q == SEND),
    .tick (tick)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs. Readiness depends only on state and
  // counters, never on s_valid, so there is no combinational loop through
  // the producer.
  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        ready  = 1'b1;
        accept = s.s_valid;
        if (accept) begin
          state_d = SEND;
        end
      end
      SEND: begin
        busy = 1'b1;
        // Opening the handshake in the last stop-bit cycle lets the next
        // start bit follow the stop bits with no idle gap on the line.
        frame_end = tick && (bit_cnt_q == LAST_BIT);
        ready     = frame_end;
        accept    = frame_end && s.s_valid;
        if (frame_end && !accept) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s.s_ready = ready;

  // Shift register and bit index. The register idles at all ones, which is
  // what keeps tx high between frames without a separate tx flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q   <= '1;
      bit_cnt_q <= '0;
    end else if (accept) begin
      shift_q   <= {{STOP_BITS{1'b1}}, s.s_data, 1'b0};
      bit_cnt_q <= '0;
    end else if ((state_q == SEND) && tick) begin
      shift_q   <= {1'b1, shift_q[PACKET_SIZE-1:1]};
      bit_cnt_q <= frame_end ? '0 : bit_cnt_q + BIT_W'(1);
    end
  end

  assign tx = shift_q[0];

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;
  import uart_tx_serializer_pkg::*;

  localparam int CPP   = 4;
  localparam int BPW   = 8;
  localparam int PS    = 13;
  localparam int FRAME = PS * CPP;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance (4 clocks/bit, 13-bit frame)
  uart_tx_serializer_if #(.BITS_PER_WORD(BPW)) bus ();
  logic tx, busy;
  uart_tx_serializer #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(BPW), .PACKET_SIZE(PS)) dut (
    .clk(clk), .rstn(rstn), .s(bus), .tx(tx), .busy(busy));

  // Sweep instances: fastest legal bit period and the real 115200 baud period, 10-bit frame
  uart_tx_serializer_if #(.BITS_PER_WORD(BPW)) bus2 ();
  logic tx2, busy2;
  uart_tx_serializer #(.CLOCKS_PER_PULSE(2), .BITS_PER_WORD(BPW), .PACKET_SIZE(10)) dut2 (
    .clk(clk), .rstn(rstn), .s(bus2), .tx(tx2), .busy(busy2));

  uart_tx_serializer_if #(.BITS_PER_WORD(BPW)) bus3 ();
  logic tx3, busy3;
  uart_tx_serializer #(.CLOCKS_PER_PULSE(434), .BITS_PER_WORD(BPW), .PACKET_SIZE(10)) dut3 (
    .clk(clk), .rstn(rstn), .s(bus3), .tx(tx3), .busy(busy3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference line level k cycles after the accepting edge: bit index k/cpp,
  // 0 = start (low), 1..BPW = data LSB first, anything later = stop (high).
  function automatic logic exp_bit(input int k, input int cpp, input logic [7:0] d);
    int idx;
    idx = k / cpp;
    if (idx == 0) return 1'b0;
    if (idx <= BPW) return d[idx-1];
    return 1'b1;
  endfunction

  // Called at a negedge with s_valid already high (or with a handshake due at
  // the coming edge). Checks nk cycles of the frame, then at k==0 drives the
  // next values of s_valid/s_data.
  task automatic watch_frame(input logic [7:0] d, input int nk, input logic nv,
                             input logic [7:0] nd, input string tag);
    logic [7:0] rxw;
    rxw = 8'h00;
    for (int k = 0; k < nk; k++) begin
      @(negedge clk);
      chk({tag, " tx"}, 32'(tx), 32'(exp_bit(k, CPP, d)));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " s_ready"}, 32'(bus.s_ready), 32'(k == FRAME - 1));
      if ((k % CPP == CPP / 2) && (k / CPP >= 1) && (k / CPP <= BPW)) rxw[k/CPP-1] = tx;
      if (k == 0) begin
        bus.s_valid = nv;
        bus.s_data  = nd;
      end
    end
    if (nk == FRAME) chk({tag, " decode"}, 32'(rxw), 32'(d));
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, " idle tx"}, 32'(tx), 32'd1);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle s_ready"}, 32'(bus.s_ready), 32'd1);
  endtask

  // Sweep instances: full per-cycle comparison, busy length and mid-bit decode.
  task automatic measure(input int sel, input int cpp, input logic [7:0] d, input string tag);
    int         f;
    int         bcnt;
    logic       t;
    logic       b;
    logic [7:0] rxw;
    f    = 10 * cpp;
    bcnt = 0;
    rxw  = 8'h00;
    @(negedge clk);
    if (sel == 2) begin bus2.s_data = d; bus2.s_valid = 1'b1; end
    else          begin bus3.s_data = d; bus3.s_valid = 1'b1; end
    for (int k = 0; k < f; k++) begin
      @(negedge clk);
      t = (sel == 2) ? tx2 : tx3;
      b = (sel == 2) ? busy2 : busy3;
      if (k == 0) begin bus2.s_valid = 1'b0; bus3.s_valid = 1'b0; end
      chk({tag, " tx"}, 32'(t), 32'(exp_bit(k, cpp, d)));
      if (b) bcnt++;
      if ((k % cpp == cpp / 2) && (k / cpp >= 1) && (k / cpp <= BPW)) rxw[k/cpp-1] = t;
    end
    @(negedge clk);
    t = (sel == 2) ? tx2 : tx3;
    b = (sel == 2) ? busy2 : busy3;
    chk({tag, " end tx"}, 32'(t), 32'd1);
    chk({tag, " end busy"}, 32'(b), 32'd0);
    chk({tag, " busy cycles"}, 32'(bcnt), 32'(f));
    chk({tag, " rx decode"}, 32'(rxw), 32'(d));
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] words[3];
    bus.s_valid  = 1'b0; bus.s_data  = 8'h00;
    bus2.s_valid = 1'b0; bus2.s_data = 8'h00;
    bus3.s_valid = 1'b0; bus3.s_data = 8'h00;
    rstn = 1'b0;

    // Reset held: toggling s_valid must have no effect
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst tx", 32'(tx), 32'd1);
      chk("rst s_ready", 32'(bus.s_ready), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst tx2", 32'(tx2), 32'd1);
      bus.s_valid = (i % 2 == 0);
      bus.s_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) idle_check("post-rst");

    // Single word
    bus.s_valid = 1'b1; bus.s_data = 8'hA5;
    watch_frame(8'hA5, FRAME, 1'b0, 8'($urandom), "a5");
    idle_check("a5");

    // Random single words
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom);
      bus.s_valid = 1'b1; bus.s_data = d;
      watch_frame(d, FRAME, 1'b0, 8'($urandom), "rand");
      idle_check("rand");
    end

    // Back-to-back 0x00 then 0xFF with s_valid held
    bus.s_valid = 1'b1; bus.s_data = 8'h00;
    watch_frame(8'h00, FRAME, 1'b1, 8'hFF, "b2b0");
    watch_frame(8'hFF, FRAME, 1'b0, 8'h00, "b2b1");
    idle_check("b2b");

    // Data changes during SEND are ignored; the pending word goes next
    bus.s_valid = 1'b1; bus.s_data = 8'h3C;
    watch_frame(8'h3C, FRAME, 1'b1, 8'hFF, "hold");
    watch_frame(8'hFF, FRAME, 1'b0, 8'h00, "hold-next");
    idle_check("hold");

    // Random back-to-back burst
    for (int n = 0; n < 3; n++) words[n] = 8'($urandom);
    bus.s_valid = 1'b1; bus.s_data = words[0];
    watch_frame(words[0], FRAME, 1'b1, words[1], "burst0");
    watch_frame(words[1], FRAME, 1'b1, words[2], "burst1");
    watch_frame(words[2], FRAME, 1'b0, 8'h00, "burst2");
    idle_check("burst");

    // Reset during data bit 3 of 0x55 (bit index 4, cycles 16..19)
    bus.s_valid = 1'b1; bus.s_data = 8'h55;
    watch_frame(8'h55, 18, 1'b0, 8'h00, "mid");
    #2 rstn = 1'b0;
    #1;
    chk("mid-rst tx", 32'(tx), 32'd1);
    chk("mid-rst busy", 32'(busy), 32'd0);
    chk("mid-rst s_ready", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    chk("mid-rst held tx", 32'(tx), 32'd1);
    rstn = 1'b1;
    idle_check("after-mid");
    idle_check("after-mid");
    bus.s_valid = 1'b1; bus.s_data = 8'h81;
    watch_frame(8'h81, FRAME, 1'b0, 8'h00, "81");
    idle_check("81");

    // Parameter sweep with 10-bit frames
    measure(2, 2, 8'h5A, "sweep2");
    measure(3, 434, 8'h5A, "sweep434");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
